// File: rtl/bram_if_pkg.sv
// Shared BRAM-side definitions for the vector reader and result writer.
// Build macro BRAM_OUTREG_EN selects the BRAM output-register latency (LAT=2).
package bram_if_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_e;

  localparam int RESULT_BASED_ADDRESS = 5;

`ifdef BRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  function automatic int calc_num_words(input int out_w, input int in_w);
    return out_w / in_w;
  endfunction

endpackage

// File: rtl/bram_read_tag_pipe.sv
// Delays the BRAM issue strobe by the read latency so capture lines up with
// the returning data word.
module bram_read_tag_pipe
  import bram_if_pkg::*;
#(
  parameter int DEPTH = LAT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic issue_i,
  output logic cap_o
);

  logic [DEPTH:1] vld_pipe_q;

  for (genvar i = 1; i <= DEPTH; i++) begin : g_stage
    if (i == 1) begin : g_first
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) vld_pipe_q[1] <= 1'b0;
        else        vld_pipe_q[1] <= issue_i;
      end
    end else begin : g_next
      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) vld_pipe_q[i] <= 1'b0;
        else        vld_pipe_q[i] <= vld_pipe_q[i-1];
      end
    end
  end

  assign cap_o = vld_pipe_q[DEPTH];

endmodule

// File: rtl/bram_reader.sv
// Fetches NUM_WORDS sequential BRAM words, packs them LSB-first into one wide
// vector and hands it over on valid/ready. Latency set by BRAM_OUTREG_EN.
module bram_reader
  import bram_if_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 13,
  parameter int DATA_IN_WIDTH  = 32,
  parameter int DATA_OUT_WIDTH = 512
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [ADDRESS_WIDTH-1:0]  base_addr_i,
  output logic [ADDRESS_WIDTH-1:0]  bram_addr,
  output logic                      bram_en,
  output logic                      bram_we,
  input  logic [DATA_IN_WIDTH-1:0]  bram_data_i,
  output logic [DATA_OUT_WIDTH-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int NUM_WORDS = calc_num_words(DATA_OUT_WIDTH, DATA_IN_WIDTH);
  localparam int CW        = $clog2(NUM_WORDS) + 1;

  state_e                    state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic                      en_q, en_d;
  logic [CW-1:0]             issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]             cap_cnt_q, cap_cnt_d;
  logic [DATA_OUT_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_OUT_WIDTH-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      done_q, done_d;
  logic                      tag_cap, cap;

  bram_read_tag_pipe #(.DEPTH(LAT)) u_tag_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .issue_i (en_q),
    .cap_o   (tag_cap)
  );

  // Tags only count while a fetch is live; anything else on the bus is ignored.
  assign cap = tag_cap && (state_q == ISSUE || state_q == DRAIN);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    en_d        = en_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    acc_d       = acc_q;
    data_d      = data_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d      = base_addr_i;
          en_d        = 1'b1;
          issue_cnt_d = CW'(1);
          cap_cnt_d   = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        addr_d = addr_q + 1'b1;
        if (issue_cnt_q == CW'(NUM_WORDS)) begin
          en_d    = 1'b0;
          state_d = DRAIN;
        end else begin
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
      end
      DRAIN: ;
      HOLD: begin
        if (valid_q && ready_i) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Final capture publishes the accumulator including the word arriving now.
    if (cap) begin
      acc_d     = {bram_data_i, acc_q[DATA_OUT_WIDTH-1:DATA_IN_WIDTH]};
      cap_cnt_d = cap_cnt_q + 1'b1;
      if (cap_cnt_q == CW'(NUM_WORDS - 1)) begin
        data_d  = acc_d;
        valid_d = 1'b1;
        state_d = HOLD;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      en_q        <= 1'b0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      acc_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      en_q        <= en_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      acc_q       <= acc_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  assign bram_addr = addr_q;
  assign bram_en   = en_q;
  assign bram_we   = 1'b0;
  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;

endmodule

// File: doc/bram_reader.md
Name: bram_reader

Overview:
- Upstream counterpart of the result writer: fetches one wide operand vector from a 32-bit-wide BRAM port and assembles it into one DATA_OUT_WIDTH word for the compute engine.
- Issues NUM_WORDS sequential reads from a start address and compensates for BRAM read latency.
- Packs the words LSB-first, so word at address A lands in bits [31:0], matching the writer's emit order.
- Presents the word on a valid/ready handshake, then pulses done_o.

Parameters:
- ADDRESS_WIDTH, 13: BRAM address width.
- DATA_IN_WIDTH, 32: BRAM read-data width.
- DATA_OUT_WIDTH, 512: assembled output width; must be an integer multiple of DATA_IN_WIDTH.
- NUM_WORDS, DATA_OUT_WIDTH/DATA_IN_WIDTH (16): reads per vector; derived, not overridden.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-low.
- start_i  input  1  request one vector fetch; sampled only in IDLE.
- base_addr_i  input  ADDRESS_WIDTH  first BRAM address; sampled with start_i.
- bram_addr  output  ADDRESS_WIDTH  registered read address.
- bram_en  output  1  registered BRAM enable.
- bram_we  output  1  constant 0.
- bram_data_i  input  DATA_IN_WIDTH  BRAM read data.
- data_o  output  DATA_OUT_WIDTH  assembled vector.
- valid_o  output  1  data_o valid.
- ready_i  input  1  consumer accepts data_o.
- busy_o  output  1  high in every state except IDLE.
- done_o  output  1  one-cycle pulse after handshake.

Behaviour:
- Reset values (asynchronous): all outputs 0, state IDLE, counters 0, accumulator 0.
- Read latency LAT = 1 cycle: data for the address driven in cycle k is valid on bram_data_i in cycle k+1.
- Issue counter and capture counter: each $clog2(NUM_WORDS)+1 bits.
- IDLE:
  - bram_en=0.
  - start_i=1 at an edge: bram_addr<=base_addr_i, bram_en<=1, issue count<=1, state<=ISSUE.
- ISSUE:
  - Each edge increments bram_addr by 1, modulo 2^ADDRESS_WIDTH (0x1FFF wraps to 0x0000, no error).
  - bram_en stays high for exactly NUM_WORDS consecutive cycles, addresses base..base+NUM_WORDS-1.
  - After the last issue: bram_en<=0, state<=DRAIN.
- Capture:
  - Runs in both ISSUE and DRAIN, driven by an issue-tag delay line of depth LAT.
  - Each tagged cycle: acc <= {bram_data_i, acc[DATA_OUT_WIDTH-1:DATA_IN_WIDTH]}, capture count +1.
  - Capture count reaching NUM_WORDS: data_o<=acc contents including the final word, valid_o<=1, state<=HOLD.
- HOLD:
  - data_o stable while valid_o=1.
  - valid_o&&ready_i at an edge: valid_o<=0, done_o<=1 for one cycle, state<=IDLE.
  - ready_i may already be high when valid_o rises; the transfer then happens on the first valid cycle.
- Timing: start accepted at edge T → valid_o high after edge T+NUM_WORDS+LAT (17 cycles at default); no extra bubble.
- start_i outside IDLE: ignored, never queued.
- start_i in the cycle done_o is high: state is already IDLE, so it is accepted; back-to-back throughput is one vector per NUM_WORDS+LAT+2 cycles.
- Reset mid-operation: immediate return to reset values; the partial vector is discarded and no done_o is issued.
- bram_data_i outside tagged cycles is ignored.

Optional Feature:
- Macro BRAM_OUTREG_EN.
- Defined: BRAM output register enabled, LAT=2; delay line depth 2; start-to-valid 18 cycles at default.
- Undefined: LAT=1 as above.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package bram_if_pkg holds:
  - state encoding IDLE/ISSUE/DRAIN/HOLD;
  - RESULT_BASED_ADDRESS=5, shared with the writer;
  - the NUM_WORDS derivation;
  - the LAT constant selected by BRAM_OUTREG_EN.
- One sub-module, bram_read_tag_pipe: LAT-deep shift register of the issue strobe, with async active-low reset, outputting the capture strobe.

Test Plan:
- Basic fetch: BRAM preloaded word i=0x1000_0000+i at addresses 5..20; start_i with base 5, ready_i=1 → valid_o 17 cycles later; data_o[31:0]=0x1000_0000, data_o[511:480]=0x1000_000F; done_o pulses 1 cycle later.
- Backpressure: ready_i=0 for 10 cycles after valid_o → data_o and valid_o stable all 10 cycles, done_o low; ready_i=1 → single transfer, done_o pulse.
- Address wrap: base 0x1FF8 → addresses 0x1FF8..0x1FFF, then 0x0000..0x0007; words packed in that order.
- Start while busy: start_i pulsed mid-ISSUE with base 0x100 → ignored, addresses unchanged, exactly one done_o.
- Reset mid-ISSUE: rst_i low after 6 issues → all outputs 0 immediately; the next start fetches a clean vector with no stale words.
- BRAM_OUTREG_EN build: repeat the basic fetch → valid_o after 18 cycles, same data_o.
